// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl: PLL reset/lock sequencer driving pll_rst, filtering pll_lock and releasing sys_rst
module pll_rst_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILT    = 8,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int HOLD_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked,
    output logic [2:0] relock_cnt,
    output logic       timeout_err
);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {S_RESET, S_WAIT, S_HOLD, S_RUN} state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [FW-1:0] r_filt, w_filt;
    logic [TW-1:0] r_tmo, w_tmo;
    logic [HW-1:0] r_hold, w_hold;
    logic          w_lock_s, w_loss, w_tmo_hit, w_inc;

    assign w_lock_s = r_sync[1];
    assign w_inc    = w_loss && (relock_cnt != 3'd7);

    // next state and counter updates; every counter restarts from zero on any state change
    always_comb begin
        w_next    = r_state;
        w_cnt     = '0;
        w_filt    = '0;
        w_tmo     = '0;
        w_hold    = '0;
        w_loss    = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_state)
            S_RESET: begin
                w_cnt  = r_cnt + 1'b1;
                w_next = (r_cnt == CW'(RST_CYCLES - 1)) ? S_WAIT : S_RESET;
            end
            S_WAIT: begin
                w_filt = w_lock_s ? r_filt + 1'b1 : '0;
                w_tmo  = r_tmo + 1'b1;
                if (r_filt == FW'(LOCK_FILT))
                    w_next = S_HOLD;
                else if (r_tmo == TW'(LOCK_TIMEOUT - 1)) begin
                    w_next    = S_RESET;
                    w_tmo_hit = 1'b1;
                end
            end
            S_HOLD: begin
                w_hold = r_hold + 1'b1;
                w_next = !w_lock_s ? S_RESET : (r_hold == HW'(HOLD_CYCLES - 1)) ? S_RUN : S_HOLD;
            end
            S_RUN: begin
                w_loss = !w_lock_s;
                w_next = (!w_lock_s || force_relock) ? S_RESET : S_RUN;
            end
            default: w_next = S_RESET;
        endcase
        if (w_next != r_state) begin
            w_cnt  = '0;
            w_filt = '0;
            w_tmo  = '0;
            w_hold = '0;
        end
    end

    // state, lock synchroniser and outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_sync      <= '0;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_tmo       <= '0;
            r_hold      <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            locked      <= 1'b0;
            relock_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sync      <= {r_sync[0], pll_lock};
            r_cnt       <= w_cnt;
            r_filt      <= w_filt;
            r_tmo       <= w_tmo;
            r_hold      <= w_hold;
            pll_rst     <= (w_next == S_RESET);
            sys_rst     <= (w_next != S_RUN);
            locked      <= (w_next == S_RUN);
            relock_cnt  <= relock_cnt + {2'b00, w_inc};
            timeout_err <= timeout_err | w_tmo_hit;
        end
    end
endmodule
